input_skew_feeder: RTL and testbench

- Sits directly downstream of the input memory (mem_arr plus input_mem_ctrl read side) and directly upstream of the systolic array's west edge.
- Takes one SYS_ROW-wide vector per cycle, all rows aligned, from the memory read port.
- Applies the diagonal skew the array needs: row r is delayed r extra cycles, with a per-row valid.
- Counts num_row vectors, drains the skew pipeline, then pulses done.

---
 rtl/sa_pkg.sv | 18 +
 rtl/skew_delay_line.sv | 41 ++++
 rtl/input_skew_feeder.sv | 111 +++++++++++
 tb/tb_input_skew_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared systolic-array types and default sizes.
// Used by the input memory, its controller and the skew feeder.
package sa_pkg;

  localparam int SA_SYS_ROW    = 16;
  localparam int SA_DATA_WIDTH = 16;
  localparam int SA_CNT_WIDTH  = 32;

  typedef logic [SA_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the west-edge skew: a {valid,data} shift register.
// Invalid entries carry zero data so stale values never reach the array.
module skew_delay_line
  import sa_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = SA_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH:0] sr_q [DEPTH];
  logic [DATA_WIDTH:0] head;

  // Zero the data of an empty slot before it enters the line.
  always_comb begin
    head = '0;
    if (in_valid) head = {1'b1, in_data};
  end

  // Shift one stage per cycle; async clear drops everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++)
        sr_q[i] <= '0;
    end else begin
      sr_q[0] <= head;
      for (int i = 1; i < DEPTH; i++)
        sr_q[i] <= sr_q[i-1];
    end
  end

  assign out_valid = sr_q[DEPTH-1][DATA_WIDTH];
  assign out_data  = sr_q[DEPTH-1][DATA_WIDTH-1:0];

endmodule

// File: rtl/input_skew_feeder.sv
// Diagonal skew between the input memory read port and the array west edge.
// Lane r is delayed r+1 cycles; done follows once the last lane has drained.
module input_skew_feeder
  import sa_pkg::*;
#(
  parameter int SYS_ROW    = SA_SYS_ROW,
  parameter int DATA_WIDTH = SA_DATA_WIDTH,
  parameter int CNT_WIDTH  = SA_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_row,
  input  logic [SYS_ROW-1:0]    in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [SYS_ROW],
  output logic [SYS_ROW-1:0]    sa_valid,
  output logic [DATA_WIDTH-1:0] sa_data [SYS_ROW],
  output logic                  busy,
  output logic                  done
);

  localparam int DW = $clog2(SYS_ROW + 1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = 1;
  localparam logic [DW-1:0] D_ONE = 1;
  localparam logic [DW-1:0] D_END = DW'(SYS_ROW - 1);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] acc_nxt;
  logic [DW-1:0]        drn_q;
  logic                 arm;
  logic                 accept;
  logic                 last;
  logic                 drn_end;

  assign arm     = (state_q == IDLE) && start;
  assign accept  = (state_q == STREAM) && in_valid[0];
  assign acc_nxt = acc_q + C_ONE;
  assign last    = accept && (acc_nxt == num_q);
  assign drn_end = (drn_q == D_END);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; DRAIN spans SYS_ROW cycles so the last
  // lane's final valid sits in the cycle before done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (num_row == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drn_end) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the length at start and count accepted vectors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_q <= '0;
      acc_q <= '0;
    end else if (arm) begin
      num_q <= num_row;
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= acc_nxt;
    end
  end

  // Drain timer, running only while in DRAIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 drn_q <= '0;
    else if (state_q == DRAIN) drn_q <= drn_q + D_ONE;
    else                       drn_q <= '0;
  end

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_lane
    logic lane_v;

    assign lane_v = accept & in_valid[r];

    skew_delay_line #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_dl (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (lane_v),
      .in_data   (in_data[r]),
      .out_valid (sa_valid[r]),
      .out_data  (sa_data[r])
    );
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder.
// Per-cycle vector table plus hand-written multi-cycle sequences.
module tb_input_skew_feeder;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] num_row;
  logic [15:0] in_valid;
  logic [15:0] in_data [16];
  logic [15:0] sa_valid;
  logic [15:0] sa_data [16];
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  input_skew_feeder #(
    .SYS_ROW    (16),
    .DATA_WIDTH (16),
    .CNT_WIDTH  (32)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .num_row  (num_row),
    .in_valid (in_valid),
    .in_data  (in_data),
    .sa_valid (sa_valid),
    .sa_data  (sa_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [31:0] nr;
    logic [15:0] vin;
    logic [15:0] din;
    logic [15:0] ev;
    logic [15:0] ed0;
    logic [15:0] ed15;
    logic        eb;
    logic        edn;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(
    logic st, logic [31:0] nr,
    logic [15:0] vin, logic [15:0] din,
    logic [15:0] ev, logic [15:0] ed0,
    logic [15:0] ed15, logic eb, logic edn);
    vec_t v;
    v.st = st;   v.nr = nr;
    v.vin = vin; v.din = din;
    v.ev = ev;   v.ed0 = ed0;
    v.ed15 = ed15;
    v.eb = eb;   v.edn = edn;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [15:0] v, logic [15:0] d);
    in_valid = v;
    for (int j = 0; j < 16; j++) in_data[j] = d;
  endtask

  task automatic go(logic [31:0] n);
    start   = 1'b1;
    num_row = n;
    tick();
    start   = 1'b0;
    num_row = '0;
  endtask

  initial begin
    logic [15:0] exp_d;
    logic [31:0] e0, e7, e15, edn;
    logic        any_v, any_d;
    int          c0, c15, cd, td;
    logic [15:0] l15;

    rstn    = 1'b0;
    start   = 1'b0;
    num_row = '0;
    drive('0, '0);
    tick();
    tick();

    chk("rst sa_valid", sa_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst data0", sa_data[0], 0);
    chk("rst data15", sa_data[15], 0);
    rstn = 1'b1;
    tick();

    // ---- basic: num_row=8, all lanes, data = vector index ----
    tbl[0]  = mk(1, 8, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 16'hFFFF, 0, 16'h0000, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 16'hFFFF, 1, 16'h0001, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 16'hFFFF, 2, 16'h0003, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 16'hFFFF, 3, 16'h0007, 2, 0, 1, 0);
    tbl[5]  = mk(0, 0, 16'hFFFF, 4, 16'h000F, 3, 0, 1, 0);
    tbl[6]  = mk(0, 0, 16'hFFFF, 5, 16'h001F, 4, 0, 1, 0);
    tbl[7]  = mk(0, 0, 16'hFFFF, 6, 16'h003F, 5, 0, 1, 0);
    tbl[8]  = mk(0, 0, 16'hFFFF, 7, 16'h007F, 6, 0, 1, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 16'h00FF, 7, 0, 1, 0);
    tbl[10] = mk(0, 0, 16'h0000, 0, 16'h01FE, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 16'h0000, 0, 16'h03FC, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 16'h0000, 0, 16'h07F8, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 16'h0000, 0, 16'h0FF0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 16'h0000, 0, 16'h1FE0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 16'h0000, 0, 16'h3FC0, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 16'h0000, 0, 16'h7F80, 0, 0, 1, 0);
    tbl[17] = mk(0, 0, 16'h0000, 0, 16'hFF00, 0, 0, 1, 0);
    tbl[18] = mk(0, 0, 16'h0000, 0, 16'hFE00, 0, 1, 1, 0);
    tbl[19] = mk(0, 0, 16'h0000, 0, 16'hFC00, 0, 2, 1, 0);
    tbl[20] = mk(0, 0, 16'h0000, 0, 16'hF800, 0, 3, 1, 0);
    tbl[21] = mk(0, 0, 16'h0000, 0, 16'hF000, 0, 4, 1, 0);
    tbl[22] = mk(0, 0, 16'h0000, 0, 16'hE000, 0, 5, 1, 0);
    tbl[23] = mk(0, 0, 16'h0000, 0, 16'hC000, 0, 6, 1, 0);
    tbl[24] = mk(0, 0, 16'h0000, 0, 16'h8000, 0, 7, 1, 0);
    tbl[25] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1);
    tbl[26] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);

    for (int k = 0; k < 27; k++) begin
      start   = tbl[k].st;
      num_row = tbl[k].nr;
      drive(tbl[k].vin, tbl[k].din);
      chk($sformatf("tbl%0d valid", k), sa_valid, tbl[k].ev);
      chk($sformatf("tbl%0d d0", k), sa_data[0], tbl[k].ed0);
      chk($sformatf("tbl%0d d15", k), sa_data[15], tbl[k].ed15);
      chk($sformatf("tbl%0d busy", k), busy, tbl[k].eb);
      chk($sformatf("tbl%0d done", k), done, tbl[k].edn);
      for (int r = 1; r < 15; r++) begin
        exp_d = tbl[k].ev[r] ? 16'(k - 2 - r) : 16'h0;
        chk($sformatf("tbl%0d lane%0d", k, r), sa_data[r], exp_d);
      end
      tick();
    end
    start = 1'b0;
    drive('0, '0);
    tick();

    // ---- zero length ----
    go(0);
    chk("zero done", done, 1);
    chk("zero busy", busy, 1);
    chk("zero valid", sa_valid, 0);
    tick();
    chk("zero done2", done, 0);
    chk("zero busy2", busy, 0);
    any_v = 1'b0;
    for (int t = 0; t < 18; t++) begin
      any_v |= |sa_valid;
      tick();
    end
    chk("zero no valid", any_v, 0);

    // ---- bubble: 2-cycle gap between vectors 2 and 3 ----
    e0  = 32'h0000_004E;
    e7  = 32'h0000_2700;
    e15 = 32'h0027_0000;
    edn = 32'h0040_0000;
    go(4);
    for (int t = 0; t < 24; t++) begin
      case (t)
        0: drive(16'hFFFF, 16'h30);
        1: drive(16'hFFFF, 16'h31);
        2: drive(16'hFFFF, 16'h32);
        5: drive(16'hFFFF, 16'h33);
        default: drive('0, 16'hDEAD);
      endcase
      chk($sformatf("bub t%0d v0", t), sa_valid[0], e0[t]);
      chk($sformatf("bub t%0d v7", t), sa_valid[7], e7[t]);
      chk($sformatf("bub t%0d v15", t), sa_valid[15], e15[t]);
      chk($sformatf("bub t%0d done", t), done, edn[t]);
      if (t == 21)
        chk("bub d15 last", sa_data[15], 16'h33);
      if (t == 19)
        chk("bub d15 gap", sa_data[15], 16'h0);
      tick();
    end
    drive('0, '0);

    // ---- partial lanes: only lanes 0..7 valid ----
    e0  = 32'h0000_001E;
    e7  = 32'h0000_0F00;
    edn = 32'h0010_0000;
    go(4);
    for (int t = 0; t < 23; t++) begin
      if (t < 4) drive(16'h00FF, 16'(16'hA000 + t));
      else       drive('0, '0);
      any_d = 1'b0;
      for (int r = 8; r < 16; r++)
        any_d |= (sa_data[r] != 0);
      chk($sformatf("part t%0d hi v", t), sa_valid[15:8], 0);
      chk($sformatf("part t%0d hi d", t), any_d, 0);
      chk($sformatf("part t%0d v0", t), sa_valid[0], e0[t]);
      chk($sformatf("part t%0d v7", t), sa_valid[7], e7[t]);
      chk($sformatf("part t%0d done", t), done, edn[t]);
      if (t == 11)
        chk("part d7", sa_data[7], 16'hA003);
      tick();
    end

    // ---- in_valid while idle ----
    any_v = 1'b0;
    for (int t = 0; t < 20; t++) begin
      drive(t < 3 ? 16'hFFFF : 16'h0, 16'h55);
      any_v |= |sa_valid;
      any_v |= busy;
      tick();
    end
    chk("idle ignore", any_v, 0);

    // ---- overrun plus restart while busy ----
    go(4);
    c0 = 0; c15 = 0; cd = 0; td = -1; l15 = '0;
    for (int t = 0; t < 26; t++) begin
      if (t < 6) drive(16'hFFFF, 16'(16'h10 + t));
      else       drive('0, '0);
      start   = (t == 2);
      num_row = (t == 2) ? 32'd99 : 32'd0;
      if (sa_valid[0]) c0++;
      if (sa_valid[15]) begin
        c15++;
        l15 = sa_data[15];
      end
      if (done) begin
        cd++;
        td = t;
      end
      tick();
    end
    start = 1'b0;
    chk("ovr lane0 cnt", c0, 4);
    chk("ovr lane15 cnt", c15, 4);
    chk("ovr lane15 last", l15, 16'h13);
    chk("ovr done cnt", cd, 1);
    chk("ovr done time", td, 20);
    chk("ovr idle after", busy, 0);

    // ---- reset mid-stream ----
    go(8);
    for (int t = 0; t < 3; t++) begin
      drive(16'hFFFF, 16'(16'h40 + t));
      tick();
    end
    drive(16'hFFFF, 16'h43);
    #2;
    rstn = 1'b0;
    #1;
    any_d = 1'b0;
    for (int r = 0; r < 16; r++)
      any_d |= (sa_data[r] != 0);
    chk("mrst valid", sa_valid, 0);
    chk("mrst data", any_d, 0);
    chk("mrst busy", busy, 0);
    chk("mrst done", done, 0);
    tick();
    rstn = 1'b1;
    any_v = 1'b0;
    for (int t = 0; t < 25; t++) begin
      drive(16'hFFFF, 16'h66);
      any_v |= |sa_valid;
      any_v |= done;
      tick();
    end
    chk("mrst quiet", any_v, 0);

    go(2);
    for (int t = 0; t < 20; t++) begin
      case (t)
        0: drive(16'hFFFF, 16'h77);
        1: drive(16'hFFFF, 16'h78);
        default: drive('0, '0);
      endcase
      if (t == 1) chk("re d0", sa_data[0], 16'h77);
      if (t == 16) chk("re d15 a", sa_data[15], 16'h77);
      if (t == 17) chk("re d15 b", sa_data[15], 16'h78);
      if (t == 17) chk("re v15 b", sa_valid[15], 1);
      if (t == 18) chk("re v15 off", sa_valid[15], 0);
      if (t == 18) chk("re done", done, 1);
      if (t == 19) chk("re done off", done, 0);
      if (t == 19) chk("re busy off", busy, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
